// File: rtl/multicycle_controller_if.sv
// Instruction-issue handshake between an instruction source (master)
// and the multicycle controller (slave).
interface multicycle_controller_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle sequencer: latches one I-type instruction, walks it through
// DECODE/EXEC/MEM/WB and drives datapath selects plus one-cycle write strobes.
module multicycle_controller #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_controller_if.slave bus,
    output logic                 RegDst,
    output logic                 ALUSrc,
    output logic [2:0]           ALUControl,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 busy,
    output logic [PC_W-1:0]      pc,
    output logic [CNT_W-1:0]     retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [PC_W-1:0]  PC_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_reg;
    logic [31:0]       ir_reg;
    logic [5:0]        sel_reg;
    logic              instr_ready_reg;
    logic              reg_write_reg;
    logic              mem_write_reg;
    logic [PC_W-1:0]   pc_reg;
    logic [CNT_W-1:0]  retired_reg;
    logic [CNT_W-1:0]  retired_next;

    // Saturating increment used on every return to IDLE.
    assign retired_next = (retired_reg == CNT_MAX) ? retired_reg : retired_reg + CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            ir_reg          <= '0;
            sel_reg         <= '0;
            instr_ready_reg <= 1'b1;
            reg_write_reg   <= 1'b0;
            mem_write_reg   <= 1'b0;
            pc_reg          <= '0;
            retired_reg     <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    reg_write_reg <= 1'b0;
                    mem_write_reg <= 1'b0;
                    if (bus.instr_valid && instr_ready_reg) begin
                        ir_reg          <= bus.instr;
                        sel_reg         <= bus.instr[31:26];
                        pc_reg          <= pc_reg + PC_ONE;
                        instr_ready_reg <= 1'b0;
                        state_reg       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (ir_reg == 32'd0) begin
                        state_reg       <= S_IDLE;
                        instr_ready_reg <= 1'b1;
                        sel_reg         <= '0;
                        retired_reg     <= retired_next;
                    end else begin
                        state_reg <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_reg <= S_MEM;
                    // Strobes are registered, so they are set one state early.
                    if (!ir_reg[26]) begin
                        mem_write_reg <= 1'b1;
                    end
                end
                S_MEM: begin
                    mem_write_reg <= 1'b0;
                    if (ir_reg[26]) begin
                        state_reg     <= S_WB;
                        reg_write_reg <= 1'b1;
                    end else begin
                        state_reg       <= S_IDLE;
                        instr_ready_reg <= 1'b1;
                        sel_reg         <= '0;
                        retired_reg     <= retired_next;
                    end
                end
                S_WB: begin
                    reg_write_reg   <= 1'b0;
                    state_reg       <= S_IDLE;
                    instr_ready_reg <= 1'b1;
                    sel_reg         <= '0;
                    retired_reg     <= retired_next;
                end
                default: begin
                    state_reg       <= S_IDLE;
                    instr_ready_reg <= 1'b1;
                    sel_reg         <= '0;
                    reg_write_reg   <= 1'b0;
                    mem_write_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.instr_ready = instr_ready_reg;
    assign busy            = ~instr_ready_reg;
    assign RegDst          = sel_reg[5];
    assign ALUSrc          = sel_reg[4];
    assign MemtoReg        = sel_reg[0];
    assign RegWrite        = reg_write_reg;
    assign MemWrite        = mem_write_reg;
    assign pc              = pc_reg;
    assign retired         = retired_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_alu_ctrl
            assign ALUControl[gi] = sel_reg[gi+1];
        end
    endgenerate

endmodule
